keypad_scan_ctrl: RTL and testbench

Scan controller for the microwave front-panel 4x3 key matrix. Drives one column at a time, samples the four row lines, debounces each candidate press and its release in the clock domain, and presents one encoded key code per physical press to the control FSM through a valid/ack handshake. Sits between the keypad pins and the microwave controller, in the encoder subsystem.

---
 rtl/keypad_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Column-scanning controller for a 4x3 key matrix. Debounces press and release
// and hands one encoded key per physical press to the consumer via valid/ack.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 16,
  parameter int DBC_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DBC_CYCLES);

  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DBC_CYCLES - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [2:0] COL0_N   = 3'b110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  logic [3:0]    r_rs_meta;
  logic [3:0]    r_rs;
  logic [1:0]    r_state;
  logic [2:0]    r_col_n;
  logic [DW-1:0] r_dwell;
  logic [SW-1:0] r_stable;
  logic [3:0]    r_pattern;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_overrun;

  logic [2:0]    w_col_next_n;
  logic          w_single_low;
  logic [3:0]    w_code;

  function automatic logic [1:0] row_index(input logic [3:0] pat);
    case (pat)
      4'b1110: row_index = 2'd0;
      4'b1101: row_index = 2'd1;
      4'b1011: row_index = 2'd2;
      default: row_index = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] col_index(input logic [2:0] cn);
    case (cn)
      3'b110:  col_index = 2'd0;
      3'b101:  col_index = 2'd1;
      default: col_index = 2'd2;
    endcase
  endfunction

  // Index = row*3 + col; positions 9..11 are CANCEL, 0 and START.
  function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] idx;
    idx = 4'(row) * 4'd3 + 4'(col);
    case (idx)
      4'd9:    encode_key = 4'hA;
      4'd10:   encode_key = 4'h0;
      4'd11:   encode_key = 4'hB;
      default: encode_key = idx + 4'd1;
    endcase
  endfunction

  // One-hot-low column drive rotated as a register, so col_n never glitches.
  assign w_col_next_n = {r_col_n[1:0], r_col_n[2]};
  assign w_single_low = ($countones(~r_rs) == 1);
  assign w_code       = encode_key(row_index(r_pattern), col_index(r_col_n));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_meta   <= ROWS_IDLE;
      r_rs        <= ROWS_IDLE;
      r_state     <= ST_SCAN;
      r_col_n     <= COL0_N;
      r_dwell     <= '0;
      r_stable    <= '0;
      r_pattern   <= ROWS_IDLE;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rs_meta <= row_n;
      r_rs      <= r_rs_meta;
      r_overrun <= 1'b0;

      // NOTE: non-blocking assignments resolve last-write-wins, so an accept
      // further down overrides this ack clear on the same edge.
      if (r_key_valid && key_ack) r_key_valid <= 1'b0;

      case (r_state)
        ST_SCAN: begin
          if (r_dwell == DWELL_LAST) begin
            r_dwell <= '0;
            if (w_single_low) begin
              r_pattern <= r_rs;
              r_stable  <= '0;
              r_state   <= ST_DEBOUNCE;
            end else begin
              r_col_n <= w_col_next_n;
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end

        ST_DEBOUNCE: begin
          if (r_rs != r_pattern) begin
            r_col_n <= w_col_next_n;
            r_dwell <= '0;
            r_state <= ST_SCAN;
          end else if (r_stable == STABLE_LAST) begin
            r_state <= ST_HOLD;
            if (!r_key_valid || key_ack) begin
              r_key_code  <= w_code;
              r_key_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_stable <= r_stable + 1'b1;
          end
        end

        ST_HOLD: begin
          if (r_rs == ROWS_IDLE) begin
            r_stable <= '0;
            r_state  <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (r_rs != ROWS_IDLE) begin
            r_state <= ST_HOLD;
          end else if (r_stable == STABLE_LAST) begin
            r_state <= ST_SCAN;
            r_col_n <= COL0_N;
            r_dwell <= '0;
          end else begin
            r_stable <= r_stable + 1'b1;
          end
        end

        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign col_n     = r_col_n;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a behavioural 4x3 matrix model driven
// from col_n, hand-timed expectations for scan, debounce, handshake and reset.
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        overrun;

  logic [11:0] pressed;
  int          n_total;
  int          n_bad;
  int          n_events;
  int          n_ovr;
  int          n_ill;
  logic        prev_valid;

  keypad_scan_ctrl #(.SCAN_DIV(16), .DBC_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid && !prev_valid) n_events++;
    prev_valid = key_valid;
    if (overrun) n_ovr++;
    if (!(col_n inside {3'b110, 3'b101, 3'b011})) n_ill++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_col(input string tag, input logic [2:0] target, input int budget);
    int n = 0;
    while (col_n !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, col_n, target);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (key_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, key_valid, 1);
  endtask

  task automatic pulse_ack();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
  endtask

  initial begin
    int ev;
    int w;
    n_total = 0; n_bad = 0; n_events = 0; n_ovr = 0; n_ill = 0;
    prev_valid = 1'b0;
    rst_n = 1'b0; key_ack = 1'b0; pressed = '0;
    tick(3);
    check("rst_col", col_n, 3'b110);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 4'h0);
    check("rst_ovr", overrun, 0);

    // Idle scan: 16 cycles per column
    rst_n = 1'b1;
    tick(15); check("idle_c0_end", col_n, 3'b110);
    tick(1);  check("idle_c1", col_n, 3'b101);
    tick(16); check("idle_c2", col_n, 3'b011);
    tick(16); check("idle_wrap", col_n, 3'b110);
    check("idle_valid", key_valid, 0);

    // Key 8 (row 2, col 1): detect at E+16, valid at E+24
    pressed[7] = 1'b1;
    wait_col("k8_col1", 3'b101, 40);
    tick(23);
    check("k8_early", key_valid, 0);
    check("k8_col_held", col_n, 3'b101);
    tick(1);
    check("k8_valid", key_valid, 1);
    check("k8_code", key_code, 4'h8);
    tick(2);
    check("k8_pre_ack", key_valid, 1);
    pulse_ack();
    check("k8_acked", key_valid, 0);
    tick(200);
    check("k8_hold_events", n_events, 1);
    pressed = '0;
    tick(10); check("k8_rel_hold", col_n, 3'b101);
    tick(1);  check("k8_rel_col0", col_n, 3'b110);

    // Bouncy press / release of key 1
    for (int i = 0; i < 14; i++) begin
      pressed[0] = (i % 2 == 0);
      tick(3);
    end
    check("bounce_no_event", n_events, 1);
    pressed[0] = 1'b1;
    wait_valid("bounce_valid", 150);
    check("bounce_code", key_code, 4'h1);
    check("bounce_events", n_events, 2);
    pulse_ack();
    for (int i = 0; i < 14; i++) begin
      pressed[0] = (i % 2 == 1);
      tick(3);
    end
    pressed = '0;
    tick(60);
    check("bounce_rel_events", n_events, 2);
    check("bounce_rel_valid", key_valid, 0);

    // Two rows low on column 1: rejected, scan moves on
    pressed[1] = 1'b1; pressed[4] = 1'b1;
    wait_col("dual_sync", 3'b011, 60);
    wait_col("dual_col1", 3'b101, 60);
    tick(16);
    check("dual_advance", col_n, 3'b011);
    tick(100);
    check("dual_events", n_events, 2);
    pressed = '0;
    tick(5);

    // START without ack, then key 5 -> overrun
    pressed[11] = 1'b1;
    wait_valid("start_valid", 150);
    check("start_code", key_code, 4'hB);
    tick(2);
    pressed = '0;
    tick(20);
    pressed[4] = 1'b1;
    w = 0;
    while (overrun !== 1'b1 && w < 150) begin
      tick();
      w++;
    end
    check("ovr_pulse", overrun, 1);
    check("ovr_code_kept", key_code, 4'hB);
    check("ovr_valid_kept", key_valid, 1);
    tick(1);
    check("ovr_one_cycle", overrun, 0);
    check("ovr_count", n_ovr, 1);
    pressed = '0;
    tick(20);

    // Key 5 with ack on the accept edge
    wait_col("same_sync", 3'b011, 60);
    pressed[4] = 1'b1;
    wait_col("same_col1", 3'b101, 60);
    tick(23);
    check("same_pre_code", key_code, 4'hB);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    check("same_valid", key_valid, 1);
    check("same_code", key_code, 4'h5);
    check("same_no_ovr", n_ovr, 1);
    check("same_events", n_events, 3);
    pressed = '0;
    tick(20);

    // Reset during DEBOUNCE of key 8
    wait_col("rdb_sync", 3'b011, 60);
    pressed[7] = 1'b1;
    wait_col("rdb_col1", 3'b101, 60);
    tick(20);
    rst_n = 1'b0;
    #1;
    check("rdb_col", col_n, 3'b110);
    check("rdb_valid", key_valid, 0);
    check("rdb_code", key_code, 4'h0);
    check("rdb_ovr", overrun, 0);
    pressed = '0;
    tick(3);
    rst_n = 1'b1;
    tick(15); check("rdb_restart_c0", col_n, 3'b110);
    tick(1);  check("rdb_restart_c1", col_n, 3'b101);
    check("rdb_no_valid", key_valid, 0);

    // Reset during HOLD of key 1
    pressed[0] = 1'b1;
    wait_valid("rhd_valid", 150);
    check("rhd_code", key_code, 4'h1);
    tick(5);
    ev = n_events;
    rst_n = 1'b0;
    #1;
    check("rhd_valid0", key_valid, 0);
    check("rhd_code0", key_code, 4'h0);
    check("rhd_col", col_n, 3'b110);
    pressed = '0;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    check("rhd_no_event", n_events, ev);
    check("rhd_no_ovr", n_ovr, 1);
    check("rhd_valid_idle", key_valid, 0);

    check("col_legal", n_ill, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
